serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial, LSB-first subtractor computing a − b − bin over WIDTH clock cycles through a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction counterpart of the team's combinational full-adder cell. It trades area for latency and sits beside the adder datapath wherever a narrow, low-gate-count difference/compare unit is needed. A start/busy/done handshake lets a controller issue one operation at a time.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only while idle.
- a  in  WIDTH  minuend; captured on accepted start.
- b  in  WIDTH  subtrahend; captured on accepted start.
- bin  in  1  borrow-in; captured on accepted start.
- busy  out  1  high while an operation is shifting.
- done  out  1  one-cycle pulse when diff/bout become valid.
- diff  out  WIDTH  a − b − bin mod 2^WIDTH; held until next completion.
- bout  out  1  final borrow-out (1 when a < b + bin, unsigned).

## Operation
- Internal state:
  - IDLE, SHIFT.
  - Shift registers ra and rb, result shift register rd, borrow flop br.
  - Bit counter cnt, $clog2(WIDTH) bits wide, or 1 bit minimum.
- IDLE, start=1: ra←a, rb←b, br←bin, cnt←0, busy←1, go to SHIFT.
- IDLE, start=0: hold state. diff and bout keep their last values.
- SHIFT, each cycle, using x=ra[0], y=rb[0]:
  - d = x^y^br.
  - br ← (~x&y) | (~(x^y)&br).
  - rd ← {d, rd[WIDTH-1:1]}.
  - ra and rb shift right by one.
  - cnt ← cnt+1.
- SHIFT with cnt==WIDTH-1 (last bit):
  - diff ← {d, rd[WIDTH-1:1]}; bout ← borrow from that bit.
  - done←1, busy←0, go to IDLE.
- diff and bout change only at completion. Intermediate bits stay internal in rd and are never visible on diff.
- done is registered. It is high for exactly one cycle and then cleared.
- start while busy=1 is ignored and not queued. The a, b and bin inputs are don't-care while busy.
- start sampled in the same cycle that done is high is accepted, because the state is IDLE then. This gives back-to-back operation.
- Arithmetic is unsigned modulo 2^WIDTH. Signed interpretation is left to the consumer; no overflow flag is provided.

## Timing
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, diff=0, bout=0, cnt=0, br=0.
  - rst has priority over start and over any in-flight operation.
- Reset mid-operation aborts the operation: no done pulse, and diff/bout read 0.
- Latency:
  - Let E0 be the edge at which start is accepted.
  - busy is high for cycles E0+1 through E0+WIDTH, i.e. exactly WIDTH cycles.
  - At edge E0+WIDTH: busy falls, done rises, and diff/bout update, all together.
- Throughput: one operation per WIDTH+1 cycles if start is held high continuously. The extra cycle is the done/IDLE cycle.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan
- Basic subtraction: WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulsed. Required:
  - busy high exactly 8 cycles.
  - done pulses 1 cycle.
  - diff=0x1E, bout=0.
- Underflow: a=0x00, b=0x01, bin=0. Required: diff=0xFF, bout=1.
- Borrow-in propagation: a=0x80, b=0x7F, bin=1. Required: diff=0x00, bout=0.
- Start while busy:
  - Start a=0x10, b=0x01.
  - Re-assert start with a=0xFF, b=0x00 on cycle 3 of busy.
  - Required: result diff=0x0F, and no second operation begins.
- Reset mid-operation: assert rst on cycle 4 of busy. Required:
  - busy=0, diff=0x00, bout=0 on the next cycle.
  - No done pulse follows.
  - A subsequent start of 0x03−0x05 gives diff=0xFE, bout=1.
- Back-to-back and random operations:
  - Hold start=1 across two operations, 0xF0−0x0F then 0x01−0x02. Required: diff=0xE1/bout=0, then diff=0xFF/bout=1, with done pulses exactly 9 cycles apart.
  - Then run 1000 random operations with WIDTH=8 and WIDTH=16, checked against a − b − bin.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first subtractor: diff = a - b - bin (mod 2^WIDTH), bout = borrow.
// One full-subtractor cell is reused every cycle. A borrow flop carries the borrow
// between bit positions. The start/busy/done handshake allows one operation at a time.

// Single-bit full subtractor. This is the borrow-direction twin of the full-adder cell.
module serial_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of x - y - bin
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // The result register holds only the WIDTH-1 bits already produced. The bit made
  // in the final cycle goes straight into diff, so a full WIDTH-bit register would
  // carry an LSB slot that nothing ever reads.
  localparam int unsigned RD_W = WIDTH - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Control and output state (reset)
  state_t           state_q, state_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] diff_q,  diff_d;
  logic             bout_q,  bout_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             br_q,    br_d;

  // Operand and partial-result shift registers (not reset)
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [RD_W-1:0]  rd_q, rd_d;

  // Full-subtractor cell outputs for the current bit position
  logic cell_d;
  logic cell_bo;

  serial_subtractor_cell u_cell (
    .x    (ra_q[0]),
    .y    (rb_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bo)
  );

  // Next-state and next-output logic for the IDLE/SHIFT sequencer
  always_comb begin
    // NOTE: every signal gets a default before the case. Without the defaults, a
    // path that leaves a signal unassigned would infer a latch.
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rd_d    = rd_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          br_d    = bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        br_d  = cell_bo;
        rd_d  = RD_W'({cell_d, rd_q} >> 1);
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d  = {cell_d, rd_q};
          bout_d  = cell_bo;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All flops then update
    // together from the same pre-edge values, and there is no ordering race.
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
    end
  end

  // Datapath shift registers, loaded on start and shifted while in SHIFT
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are deliberately left out of reset. They are
    // always loaded on an accepted start before they are read, so resetting them
    // would add reset fan-out and buy nothing.
    ra_q <= ra_d;
    rb_q <= rb_d;
    rd_q <= rd_d;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor, with WIDTH=8 and WIDTH=16 instances.
// Expected results come from plain unsigned arithmetic on a, b and bin.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;

  logic        start8,  bin8,  busy8,  done8,  bout8;
  logic [7:0]  a8, b8, diff8;
  logic        start16, bin16, busy16, done16, bout16;
  logic [15:0] a16, b16, diff16;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst   (rst),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .bin   (bin16),
    .busy  (busy16),
    .done  (done16),
    .diff  (diff16),
    .bout  (bout16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic bi);
    if (w == 8) begin
      start8 = s; a8 = a[7:0]; b8 = b[7:0]; bin8 = bi;
    end else begin
      start16 = s; a16 = a[15:0]; b16 = b[15:0]; bin16 = bi;
    end
  endtask

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done16;
  endfunction

  function automatic logic [31:0] get_diff(input int w);
    return (w == 8) ? {24'd0, diff8} : {16'd0, diff16};
  endfunction

  function automatic logic get_bout(input int w);
    return (w == 8) ? bout8 : bout16;
  endfunction

  // Reference model: unsigned difference modulo 2^w, borrow when a < b + bin.
  function automatic logic [31:0] model_diff(input int w, input logic [31:0] a, input logic [31:0] b,
                                             input logic bi);
    longint m, r;
    m = (longint'(1) << w) - 1;
    r = longint'(a) - longint'(b) - longint'(bi);
    return 32'(r & m);
  endfunction

  function automatic logic model_bout(input logic [31:0] a, input logic [31:0] b, input logic bi);
    return longint'(a) < (longint'(b) + longint'(bi));
  endfunction

  // Called at the sample after the accepting edge. Counts busy samples until done is seen.
  task automatic wait_done(input int w, input int budget, output int busy_n, output bit timed_out);
    busy_n    = 0;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (get_done(w)) begin
        timed_out = 1'b0;
        break;
      end
      if (get_busy(w)) busy_n++;
      step();
    end
  endtask

  // Issue one operation and wait for its completion. Operands are scrambled while busy.
  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic bi,
                       output logic [31:0] diff, output logic bout, output int busy_n,
                       output bit timed_out);
    drive(w, 1'b1, a, b, bi);
    step();
    drive(w, 1'b0, $urandom, $urandom, 1'($urandom));
    wait_done(w, 3 * w, busy_n, timed_out);
    diff = get_diff(w);
    bout = get_bout(w);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(8, 1'b0, 0, 0, 1'b0);
    drive(16, 1'b0, 0, 0, 1'b0);
    step();
    step();
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
    checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done8 got=%b exp=0", done8); end
    checks++; if (diff8 !== 8'h00) begin failures++; $display("FAIL reset_diff8 got=%h exp=00", diff8); end
    checks++; if (bout8 !== 1'b0) begin failures++; $display("FAIL reset_bout8 got=%b exp=0", bout8); end
    checks++; if (busy16 !== 1'b0 || done16 !== 1'b0 || diff16 !== 16'h0 || bout16 !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut16 got busy=%b done=%b diff=%h bout=%b exp all 0", busy16, done16, diff16, bout16);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fixed(input string name, input logic [7:0] a, input logic [7:0] b, input logic bi,
                            input logic [7:0] exp_d, input logic exp_b);
    logic [31:0] d;
    logic bo;
    int n;
    bit to;
    do_op(8, {24'd0, a}, {24'd0, b}, bi, d, bo, n, to);
    checks++; if (to) begin failures++; $display("FAIL %s_timeout got=no done exp=done", name); end
    checks++; if (n != 8) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=8", name, n); end
    checks++; if (d[7:0] !== exp_d) begin failures++; $display("FAIL %s_diff got=%h exp=%h", name, d[7:0], exp_d); end
    checks++; if (bo !== exp_b) begin failures++; $display("FAIL %s_bout got=%b exp=%b", name, bo, exp_b); end
    step();
    checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL %s_done_width got=%b exp=0", name, done8); end
  endtask

  task automatic test_start_while_busy();
    int n, seen_busy;
    bit to;
    drive(8, 1'b1, 32'h10, 32'h01, 1'b0);
    step();                               // busy cycle 1
    drive(8, 1'b0, 0, 0, 1'b0);
    step();                               // busy cycle 2
    step();                               // busy cycle 3
    drive(8, 1'b1, 32'hFF, 32'h00, 1'b0);
    step();
    drive(8, 1'b0, 0, 0, 1'b0);
    wait_done(8, 30, n, to);
    checks++; if (to) begin failures++; $display("FAIL swb_timeout got=no done exp=done"); end
    checks++; if (diff8 !== 8'h0F || bout8 !== 1'b0) begin
      failures++; $display("FAIL swb_result got=%h/%b exp=0f/0", diff8, bout8);
    end
    seen_busy = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (busy8 || done8) seen_busy++;
    end
    checks++; if (seen_busy != 0) begin failures++; $display("FAIL swb_no_second_op got=%0d active cycles exp=0", seen_busy); end
  endtask

  task automatic test_reset_mid_op();
    int dones;
    logic [31:0] d;
    logic bo;
    int n;
    bit to;
    drive(8, 1'b1, 32'h77, 32'h11, 1'b0);
    step();                               // busy cycle 1
    drive(8, 1'b0, 0, 0, 1'b0);
    step();
    step();
    step();                               // busy cycle 4
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0 || done8 !== 1'b0) begin
      failures++;
      $display("FAIL rmo_after_reset got busy=%b diff=%h bout=%b done=%b exp 0/00/0/0", busy8, diff8, bout8, done8);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8 || busy8) dones++;
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL rmo_no_done got=%0d active cycles exp=0", dones); end
    do_op(8, 32'h03, 32'h05, 1'b0, d, bo, n, to);
    checks++; if (to || d[7:0] !== 8'hFE || bo !== 1'b1) begin
      failures++; $display("FAIL rmo_followup got=%h/%b timeout=%0d exp=fe/1", d[7:0], bo, to);
    end
  endtask

  task automatic test_back_to_back();
    int n, c1, c2;
    bit to;
    drive(8, 1'b1, 32'hF0, 32'h0F, 1'b0);
    step();                               // first op accepted
    drive(8, 1'b1, 32'h01, 32'h02, 1'b0);  // start still high; operands for the next op
    wait_done(8, 30, n, to);
    c1 = cyc;
    checks++; if (to || diff8 !== 8'hE1 || bout8 !== 1'b0) begin
      failures++; $display("FAIL b2b_first got=%h/%b timeout=%0d exp=e1/0", diff8, bout8, to);
    end
    step();                               // second op accepted on the done-cycle edge
    drive(8, 1'b0, 0, 0, 1'b0);
    checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL b2b_second_accept got busy=%b exp=1", busy8); end
    wait_done(8, 30, n, to);
    c2 = cyc;
    checks++; if (to || diff8 !== 8'hFF || bout8 !== 1'b1) begin
      failures++; $display("FAIL b2b_second got=%h/%b timeout=%0d exp=ff/1", diff8, bout8, to);
    end
    checks++; if (c2 - c1 != 9) begin failures++; $display("FAIL b2b_spacing got=%0d exp=9", c2 - c1); end
    step();
  endtask

  task automatic test_random(input int w, input int count);
    logic [31:0] mask, a, b, d, ed;
    logic bi, bo, eb;
    int n;
    bit to;
    mask = 32'((longint'(1) << w) - 1);
    for (int k = 0; k < count; k++) begin
      a  = $urandom & mask;
      b  = $urandom & mask;
      bi = 1'($urandom_range(0, 1));
      if (k % 5 == 0) begin
        a = (k % 10 == 0) ? 32'd0 : mask;   // corner operands
      end
      ed = model_diff(w, a, b, bi);
      eb = model_bout(a, b, bi);
      do_op(w, a, b, bi, d, bo, n, to);
      checks++;
      if (to || n != w || d !== ed || bo !== eb) begin
        failures++;
        $display("FAIL rand_w%0d op=%0d a=%h b=%h bin=%b got diff=%h bout=%b busy=%0d to=%0d exp diff=%h bout=%b busy=%0d",
                 w, k, a, b, bi, d, bo, n, to, ed, eb, w);
      end
      if ($urandom_range(0, 3) == 0) step();
    end
  endtask

  initial begin
    drive(8, 1'b0, 0, 0, 1'b0);
    drive(16, 1'b0, 0, 0, 1'b0);
    rst = 1'b1;
    test_reset();
    test_fixed("basic", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    test_fixed("underflow", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    test_fixed("borrow_in", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_random(8, 1000);
    test_random(16, 1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
